// File: rtl/nts_api_bridge_pkg.sv
// Shared definitions for the nts_api host-side command bridge.
// Holds the nts_api bus widths, the FSM state encoding, the default data
// word returned on a timed-out read, and a saturating counter helper.
package nts_api_bridge_pkg;

    localparam int API_ADDR_W = 12;
    localparam int API_DATA_W = 32;

    localparam logic [API_DATA_W-1:0] TIMEOUT_DATA_DEFAULT = 32'hDEAD_BEEF;

    // FSM state encoding (2-bit)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/nts_api_bridge.sv
// nts_api_bridge
// Host-side command sequencer in front of nts_api. Takes one register
// command per valid/ready handshake, issues it as a single-cycle cs on the
// nts_api external bus, waits for completion (read_data_valid for reads,
// busy low for writes) and returns read results on a valid/ready response
// channel. Every transaction is bounded by TIMEOUT_CYCLES wait cycles.
//
// Ports
//   i_clk, i_areset_n        clock, asynchronous active-low reset
//   i_cmd_*, o_cmd_ready     host command channel (we, address, write data)
//   o_rsp_*, i_rsp_ready     read response channel (data, timeout flag)
//   o_timeout_count          saturating count of abandoned transactions
//   o_api_*                  registered drive of the nts_api external bus
//   i_api_*                  busy / read data / read data valid from nts_api
//
// Parameters
//   TIMEOUT_CYCLES  WAIT cycles before a transaction is abandoned (>= 2)
//   TIMEOUT_DATA    rsp_data returned for a timed-out read
module nts_api_bridge
    import nts_api_bridge_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter logic [API_DATA_W-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_areset_n,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [API_ADDR_W-1:0] i_cmd_address,
    input  logic [API_DATA_W-1:0] i_cmd_write_data,

    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [API_DATA_W-1:0] o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic [7:0]            o_timeout_count,

    output logic                  o_api_cs,
    output logic                  o_api_we,
    output logic [API_ADDR_W-1:0] o_api_address,
    output logic [API_DATA_W-1:0] o_api_write_data,
    input  logic                  i_api_busy,
    input  logic [API_DATA_W-1:0] i_api_read_data,
    input  logic                  i_api_read_data_valid
);

    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    // The counter holds 0 in the first WAIT cycle, so this value marks the
    // TIMEOUT_CYCLES-th WAIT cycle: the last one in which completion counts.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]            state_reg;
    logic [CNT_W-1:0]      wait_cnt_reg;
    logic                  api_cs_reg;
    logic                  api_we_reg;
    logic [API_ADDR_W-1:0] api_address_reg;
    logic [API_DATA_W-1:0] api_write_data_reg;
    logic                  rsp_valid_reg;
    logic [API_DATA_W-1:0] rsp_data_reg;
    logic                  rsp_timeout_reg;
    logic [7:0]            timeout_count_reg;

    logic cmd_ready;
    logic cmd_accept;
    logic rd_done;
    logic wr_done;
    logic wait_expired;

    always_comb begin
        // Ready is gated by reset so every output reads 0 while reset is held.
        cmd_ready    = i_areset_n && (state_reg == ST_IDLE) && !i_api_busy;
        cmd_accept   = cmd_ready && i_cmd_valid;
        rd_done      = (state_reg == ST_WAIT) && !api_we_reg && i_api_read_data_valid;
        wr_done      = (state_reg == ST_WAIT) && api_we_reg && !i_api_busy;
        wait_expired = (state_reg == ST_WAIT) && (wait_cnt_reg == LAST_WAIT);
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_reg          <= ST_IDLE;
            wait_cnt_reg       <= '0;
            api_cs_reg         <= 1'b0;
            api_we_reg         <= 1'b0;
            api_address_reg    <= '0;
            api_write_data_reg <= '0;
            rsp_valid_reg      <= 1'b0;
            rsp_data_reg       <= '0;
            rsp_timeout_reg    <= 1'b0;
            timeout_count_reg  <= '0;
        end else begin
            // cs is a single-cycle strobe; it is only raised on accept.
            api_cs_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        api_we_reg         <= i_cmd_we;
                        api_address_reg    <= i_cmd_address;
                        api_write_data_reg <= i_cmd_write_data;
                        api_cs_reg         <= 1'b1;
                        state_reg          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
                    // Completion is tested first so it wins over a timeout
                    // landing in the same cycle.
                    if (rd_done) begin
                        rsp_data_reg    <= i_api_read_data;
                        rsp_timeout_reg <= 1'b0;
                        rsp_valid_reg   <= 1'b1;
                        state_reg       <= ST_RESP;
                    end else if (wr_done) begin
                        state_reg <= ST_IDLE;
                    end else if (wait_expired) begin
                        timeout_count_reg <= sat_inc8(timeout_count_reg);
                        if (api_we_reg) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            rsp_data_reg    <= TIMEOUT_DATA;
                            rsp_timeout_reg <= 1'b1;
                            rsp_valid_reg   <= 1'b1;
                            state_reg       <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready      = cmd_ready;
    assign o_rsp_valid      = rsp_valid_reg;
    assign o_rsp_data       = rsp_data_reg;
    assign o_rsp_timeout    = rsp_timeout_reg;
    assign o_timeout_count  = timeout_count_reg;
    assign o_api_cs         = api_cs_reg;
    assign o_api_we         = api_we_reg;
    assign o_api_address    = api_address_reg;
    assign o_api_write_data = api_write_data_reg;

endmodule
